wb_sram_slave: RTL

- Wishbone responder (slave) that serves the core's ibus/dbus master requests from an external asynchronous 32-bit SRAM.
- Accepts classic single Wishbone cycles, inserts a fixed number of SRAM wait states, and returns a one-cycle ack with read data.
- Sits between the bus interconnect and the board SRAM pins.

---
 rtl/cpu_defs.sv | 28 ++
 rtl/sram_phy_regs.sv | 52 +++++
 rtl/wb_sram_slave.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared CPU bus definitions: Wishbone request/response bundles
// and the SRAM controller state encoding.
package cpu_defs;

    localparam int SRAM_MAX_WAIT = 15;
    localparam int SRAM_CNT_W = $clog2(SRAM_MAX_WAIT + 1);

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] data;
    } WishboneReq_t;

    typedef struct packed {
        logic        ack;
        logic [31:0] data;
    } WishboneRes_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } SramCtrlState_t;

endpackage

// File: rtl/sram_phy_regs.sv
// Output register bank for the asynchronous SRAM pins.
// Strobes load together on a new access and drop together on release.
module sram_phy_regs
    import cpu_defs::*;
#(
    parameter int ADDR_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_release,
    input  logic                  i_we,
    input  logic [3:0]            i_sel,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_data,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_ce_n,
    output logic                  o_oe_n,
    output logic                  o_we_n,
    output logic [3:0]            o_be_n,
    output logic [31:0]           o_dq,
    output logic                  o_dq_oe
);

    // Pin registers: load a request, or park the strobes inactive
    always_ff @(posedge clk) begin
        if (rst) begin
            o_addr  <= '0;
            o_ce_n  <= 1'b1;
            o_oe_n  <= 1'b1;
            o_we_n  <= 1'b1;
            o_be_n  <= 4'hF;
            o_dq    <= '0;
            o_dq_oe <= 1'b0;
        end else if (i_load) begin
            o_addr  <= i_addr;
            o_ce_n  <= 1'b0;
            o_oe_n  <= i_we;
            o_we_n  <= ~i_we;
            o_be_n  <= ~i_sel;
            o_dq    <= i_data;
            o_dq_oe <= i_we;
        end else if (i_release) begin
            o_ce_n  <= 1'b1;
            o_oe_n  <= 1'b1;
            o_we_n  <= 1'b1;
            o_be_n  <= 4'hF;
            o_dq_oe <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone classic slave in front of an asynchronous 32-bit SRAM.
// Optional WB_SLAVE_ERR_EN: decode BASE_ADDR and flag misses on bus_err.
module wb_sram_slave
    import cpu_defs::*;
#(
    parameter int          ADDR_WIDTH  = 20,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  WishboneReq_t          bus_req,
    output WishboneRes_t          bus_res,
`ifdef WB_SLAVE_ERR_EN
    output logic                  bus_err,
`endif
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [3:0]            sram_be_n,
    output logic [31:0]           sram_dq_o,
    output logic                  sram_dq_oe,
    input  logic [31:0]           sram_dq_i
);

    localparam logic [SRAM_CNT_W-1:0] LP_WAIT = SRAM_CNT_W'(WAIT_CYCLES);
    localparam logic [SRAM_CNT_W-1:0] LP_ONE  = SRAM_CNT_W'(1);

    SramCtrlState_t        r_state;
    SramCtrlState_t        w_state_nxt;
    logic [SRAM_CNT_W-1:0] r_cnt;
    logic [SRAM_CNT_W-1:0] w_cnt_nxt;
    logic                  r_ack;
    logic [31:0]           r_data;
    logic                  w_req;
    logic                  w_hit;
    logic                  w_miss;
    logic                  w_start;
    logic                  w_load;
    logic                  w_release;
    logic                  w_fin;
    logic                  w_capture;
    logic                  w_unused;

    assign w_req     = bus_req.cyc & bus_req.stb;
    assign w_load    = w_start & w_hit;
    assign w_capture = w_fin & ~sram_oe_n;
    assign w_unused  = ^{bus_req.addr[1:0],
                         bus_req.addr[31:ADDR_WIDTH+2],
                         BASE_ADDR};

    assign bus_res.ack  = r_ack;
    assign bus_res.data = r_data;

`ifdef WB_SLAVE_ERR_EN
    logic r_miss;
    logic r_err;

    assign w_hit   = bus_req.addr[31:ADDR_WIDTH+2]
                     == BASE_ADDR[31:ADDR_WIDTH+2];
    assign w_miss  = r_miss;
    assign bus_err = r_err;

    // Remember a decode miss and answer it with a one-cycle error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_miss <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_start) r_miss <= ~w_hit;
            r_err <= w_fin & r_miss;
        end
    end
`else
    assign w_hit  = 1'b1;
    assign w_miss = 1'b0;
`endif

    // State, wait counter, ack and read-data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_fin & ~w_miss;
            if (w_capture) r_data <= sram_dq_i;
        end
    end

    // Next state, counter and strobe control
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start     = 1'b0;
        w_release   = 1'b0;
        w_fin       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_state_nxt = ACCESS;
                    w_start     = 1'b1;
                    w_cnt_nxt   = w_hit ? LP_WAIT : '0;
                end
            end
            ACCESS: begin
                if (!bus_req.cyc) begin
                    w_state_nxt = IDLE;
                    w_release   = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ACK;
                    w_release   = 1'b1;
                    w_fin       = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - LP_ONE;
                end
            end
            ACK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    sram_phy_regs #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_phy (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_release (w_release),
        .i_we      (bus_req.we),
        .i_sel     (bus_req.sel),
        .i_addr    (bus_req.addr[ADDR_WIDTH+1:2]),
        .i_data    (bus_req.data),
        .o_addr    (sram_addr),
        .o_ce_n    (sram_ce_n),
        .o_oe_n    (sram_oe_n),
        .o_we_n    (sram_we_n),
        .o_be_n    (sram_be_n),
        .o_dq      (sram_dq_o),
        .o_dq_oe   (sram_dq_oe)
    );

endmodule
